// File: rtl/store_merge_pkg.sv
// store_merge_pkg -- shared definitions for the store_merge block.
//
// Contents:
//   SZ_BYTE / SZ_HALF / SZ_WORD / SZ_RSVD : store size encodings (req_size_i)
//   ST_IDLE .. ST_ERR                     : FSM state encoding (also seen on dbg_state)
//   WORD_BYTES                            : bytes per memory word
//   is_misaligned()                       : natural-alignment test for a size/offset pair
//   align_off()                           : offset forced down to natural alignment
package store_merge_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam int WORD_BYTES = 4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    // True when the byte offset does not sit on the natural boundary of the size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic r;
        case (size)
            SZ_HALF: r = off[0];
            SZ_WORD: r = (off != 2'b00);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Clears the offset bits that a naturally aligned access of this size cannot have.
    function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] off);
        logic [1:0] r;
        case (size)
            SZ_HALF: r = {off[1], 1'b0};
            SZ_WORD: r = 2'b00;
            default: r = off;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/store_merge_lane_merge.sv
// store_lane_merge -- combinational little-endian lane merge.
//
// Replaces the byte lanes selected by size/off in old_word with the low
// byte/half/word of new_data; every other lane keeps old_word.
//
// Ports:
//   old_word  in  32  word read back from memory
//   new_data  in  32  register value being stored
//   size      in  2   SZ_BYTE / SZ_HALF / SZ_WORD (SZ_RSVD leaves old_word untouched)
//   off       in  2   byte offset inside the word (already aligned for the size)
//   merged    out 32  resulting word
module store_lane_merge
    import store_merge_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    output logic [31:0] merged
);

    logic [31:0]           src;
    logic [WORD_BYTES-1:0] lane_en;

    // Replicating the stored unit across the word puts the right source
    // bytes in every candidate lane, so only a per-lane enable is needed.
    always_comb begin
        src     = new_data;
        lane_en = '0;
        case (size)
            SZ_BYTE: begin
                src = {4{new_data[7:0]}};
                for (int i = 0; i < WORD_BYTES; i++) begin
                    lane_en[i] = (off == 2'(i));
                end
            end
            SZ_HALF: begin
                src = {2{new_data[15:0]}};
                for (int i = 0; i < WORD_BYTES; i++) begin
                    lane_en[i] = (off[1] == 1'(i >> 1));
                end
            end
            SZ_WORD: begin
                src     = new_data;
                lane_en = '1;
            end
            default: begin
                src     = new_data;
                lane_en = '0;
            end
        endcase
    end

    always_comb begin
        merged = old_word;
        for (int i = 0; i < WORD_BYTES; i++) begin
            if (lane_en[i]) begin
                merged[8*i +: 8] = src[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/store_merge.sv
// store_merge -- converts byte/half/word stores into full-word memory writes.
//
// A byte or half store does a read-modify-write: read the containing word,
// merge the new lanes, write the word back. A word store writes directly.
//
// Configuration macro: STORE_MERGE_ALIGN_TRAP_EN
//   defined   : misaligned half/word stores end in ERR (err_o pulse, no strobes)
//   undefined : misaligned stores are aligned down and complete normally
//
// Handshakes:
//   Request side: a request is taken on a rising edge where req_valid_i and
//   req_ready_o are both high; req_ready_o is high only in IDLE. Memory side:
//   mem_rd_o / mem_wr_o stay high until the edge where mem_ack_i is high,
//   which completes that access; mem_ack_i is ignored in any other state.
//
// Ports:
//   clk_i        in   1       clock, rising edge
//   rst_i        in   1       synchronous active-low reset
//   req_valid_i  in   1       store request valid
//   req_ready_o  out  1       ready (IDLE)
//   req_size_i   in   2       00 byte, 01 half, 10 word, 11 reserved
//   addr_i       in   ADDR_W  byte address
//   data_i       in   DATA_W  register value
//   mem_addr_o   out  ADDR_W  word-aligned memory address
//   mem_rd_o     out  1       read strobe
//   mem_wr_o     out  1       write strobe
//   mem_wdata_o  out  DATA_W  write word
//   mem_rdata_i  in   DATA_W  read data, valid with mem_ack_i during a read
//   mem_ack_i    in   1       access complete
//   done_o       out  1       one-cycle completion pulse
//   err_o        out  1       one-cycle error pulse
//   dbg_state    out  3       current FSM state (ST_* encoding)
module store_merge
    import store_merge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_size_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_o,
    output logic              mem_wr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              done_o,
    output logic              err_o,
    output logic [2:0]        dbg_state
);

    logic [2:0]        state_q;
    logic [2:0]        state_d;
    logic [ADDR_W-3:0] word_addr_q;
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] merged;
    logic              accept;
    logic              req_bad;

    assign accept = req_valid_i && req_ready_o;

`ifdef STORE_MERGE_ALIGN_TRAP_EN
    assign req_bad = (req_size_i == SZ_RSVD) || is_misaligned(req_size_i, addr_i[1:0]);
`else
    assign req_bad = (req_size_i == SZ_RSVD);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (req_bad) begin
                        state_d = ST_ERR;
                    end else if (req_size_i == SZ_WORD) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (mem_ack_i) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (mem_ack_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    store_lane_merge u_lane_merge (
        .old_word (mem_rdata_i),
        .new_data (data_q),
        .size     (size_q),
        .off      (off_q),
        .merged   (merged)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            word_addr_q <= '0;
            off_q       <= '0;
            size_q      <= '0;
            data_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                word_addr_q <= addr_i[ADDR_W-1:2];
                // Aligning here is harmless in trap mode: misaligned requests go to ERR.
                off_q       <= align_off(req_size_i, addr_i[1:0]);
                size_q      <= req_size_i;
                data_q      <= data_i;
                if (req_size_i == SZ_WORD) begin
                    wdata_q <= data_i;
                end
            end
            if ((state_q == ST_READ) && mem_ack_i) begin
                wdata_q <= merged;
            end
        end
    end

    // All outputs decode from registered state, so they are glitch-free and
    // mem_rd_o / mem_wr_o can never be high together.
    assign req_ready_o = (state_q == ST_IDLE);
    assign mem_rd_o    = (state_q == ST_READ);
    assign mem_wr_o    = (state_q == ST_WRITE);
    assign done_o      = (state_q == ST_DONE);
    assign err_o       = (state_q == ST_ERR);
    assign mem_addr_o  = {word_addr_q, 2'b00};
    assign mem_wdata_o = wdata_q;
    assign dbg_state   = state_q;

endmodule

// File: doc/store_merge.md
STORE_MERGE -- requirements
Module: Store_Merge

Interface
REQ-001 Parameter: ADDR_W, 32, width of addr_i and mem_addr_o.
REQ-002 Parameter: DATA_W, 32, memory word width; only 32 is supported.
REQ-003 Port: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_i  input  1  reset; synchronous and active-low.
REQ-005 Port: req_valid_i  input  1  store request valid.
REQ-006 Port: req_ready_o  output  1  high only in IDLE; a request is accepted when req_valid_i and req_ready_o are both high.
REQ-007 Port: req_size_i  input  2  store size: 00 = byte (sb), 01 = half (sh), 10 = word (sw), 11 = reserved.
REQ-008 Port: addr_i  input  ADDR_W  byte address.
REQ-009 Port: data_i  input  32  register value; the low byte, half or full word is stored.
REQ-010 Port: mem_addr_o  output  ADDR_W  word-aligned address, with bits [1:0] = 00.
REQ-011 Port: mem_rd_o / mem_wr_o  output  1 each  memory read and write strobes; both held high until mem_ack_i.
REQ-012 Port: mem_wdata_o  output  32  full word to be written.
REQ-013 Port: mem_rdata_i  input  32  read data; valid in the cycle mem_ack_i is high during a read.
REQ-014 Port: mem_ack_i  input  1  completes the current memory access.
REQ-015 Port: done_o / err_o  output  1 each  one-cycle completion pulse and one-cycle error pulse.

Function
REQ-016 Requests are captured into internal registers on accept; later changes on the input ports do not affect an operation in progress.
REQ-017 FSM states: IDLE, READ, WRITE, DONE, ERR.
- IDLE -> WRITE for a word store.
- IDLE -> READ for a byte or half store.
- IDLE -> ERR for a misaligned address or for req_size_i = 11.
REQ-018 READ:
- Drives mem_rd_o = 1 and mem_addr_o = {addr[ADDR_W-1:2], 2'b00}.
- On mem_ack_i, captures mem_rdata_i and moves to WRITE.
REQ-019 Merge is little-endian.
- Byte: lane addr[1:0]; bits [8*addr[1:0]+7 : 8*addr[1:0]] are replaced with data[7:0].
- Half: lane addr[1]; bits [16*addr[1]+15 : 16*addr[1]] are replaced with data[15:0].
- All other bits keep the read word.
REQ-020 Word store: mem_wdata_o = data; no read is issued.
REQ-021 WRITE:
- Drives mem_wr_o = 1 with a stable mem_addr_o and mem_wdata_o.
- On mem_ack_i, moves to DONE.
REQ-022 DONE asserts done_o for exactly one cycle, then returns to IDLE.
REQ-023 ERR asserts err_o for exactly one cycle, then returns to IDLE; no memory strobe is issued.
REQ-024 Latency from accept to done_o:
- Word store with an immediate ack: 2 cycles.
- Byte or half store with immediate acks: 3 cycles.
- Each wait cycle on mem_ack_i adds 1 cycle.
REQ-025 mem_rd_o and mem_wr_o are never high in the same cycle.
REQ-026 mem_ack_i is ignored in IDLE, DONE and ERR.
REQ-027 A request presented during DONE or ERR is not accepted; it is accepted in the following IDLE cycle.

Reset
REQ-028 When rst_i is low at a clock edge:
- The FSM goes to IDLE.
- req_ready_o = 1 after release.
- mem_rd_o, mem_wr_o, done_o and err_o are 0.
- mem_addr_o, mem_wdata_o and all captured registers are 0.
REQ-029 Reset in the middle of an operation aborts it immediately with no done_o or err_o pulse; a pending mem_ack_i is ignored.

Configuration
REQ-030 Macro STORE_MERGE_ALIGN_TRAP_EN controls alignment checking.
- Defined: a half store with addr[0] = 1 or a word store with addr[1:0] != 00 goes to ERR.
- Undefined: the offending low address bits are forced to 0 (the store is aligned down) and the store completes normally; ERR is reached only for req_size_i = 11.

Structure
REQ-031 A shared package holds:
- the size encodings SZ_BYTE, SZ_HALF, SZ_WORD;
- the FSM state encoding;
- the constant WORD_BYTES = 4.
REQ-032 The lane-merge datapath is one combinational sub-module, Store_Lane_Merge.
- Inputs: old word, new data, size, addr[1:0].
- Output: merged word.

Verification
REQ-033 Word store: sw 0xDEADBEEF to 0x100 with ack in the first cycle -> no mem_rd_o; one write of 0xDEADBEEF to 0x100; done_o 2 cycles after accept.
REQ-034 Byte store: sb 0x000000AA to 0x203 with read data 0x11223344 -> read of 0x200, then write of 0xAA223344; done_o pulse.
REQ-035 Half store: sh 0x0000BEEF to 0x302 with read data 0x11223344 and 3 wait cycles per access -> write of 0xBEEF3344; done_o 9 cycles after accept.
REQ-036 Misaligned half store: sh to 0x401.
- With STORE_MERGE_ALIGN_TRAP_EN: err_o pulse and no memory strobes.
- Without it: read and write go to 0x400 with the low half merged.
REQ-037 Reset abort: rst_i low during a READ wait -> next cycle all strobes are 0 and the FSM is in IDLE; a later ack produces no done_o.
REQ-038 Back-to-back: req_valid_i held high with 3 word stores -> each is accepted only in IDLE, mem_rd_o and mem_wr_o never overlap, and there are exactly 3 done_o pulses.
